// File: rtl/switch_port_ingress.sv
// Single-port ingress receiver: validates and classifies single-beat packets, buffers them,
// and presents the head packet to the crossbar until every target output has granted it.
module switch_port_ingress #(
    parameter int PORT_ID = 0,
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [3:0]                 in_source,
    input  logic [3:0]                 in_target,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       req_valid,
    output logic [3:0]                 req_target,
    output logic [DATA_W-1:0]          req_data,
    output logic [1:0]                 req_type,
    input  logic [3:0]                 req_grant,
    output logic                       drop_pulse,
    output logic [7:0]                 err_count,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] SELF = 4'(1 << PORT_ID);

    typedef enum logic [1:0] {EMPTY, LOAD, SERVE} state_t;

    state_t state, state_next;

    logic [3:0]        tgt_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [1:0]        type_mem [DEPTH];

    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_next;
    logic [3:0]        rem;
    logic [DATA_W-1:0] head_data;
    logic [1:0]        head_type;

    logic accept, legal, push, drop, pop;

    // Class code is popcount-1: one target SDP, two MDP, three BDP.
    function automatic logic [1:0] classify(input logic [3:0] t);
        logic [2:0] n;
        n = {2'b0, t[0]} + {2'b0, t[1]} + {2'b0, t[2]} + {2'b0, t[3]};
        return 2'(n - 3'd1);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_ready   = (count != CW'(DEPTH));
    assign accept     = in_valid && in_ready;
    assign legal      = (in_source == SELF) && (in_target != 4'b0) && ((in_target & SELF) == 4'b0);
    assign push       = accept && legal;
    assign drop       = accept && !legal;
    assign pop        = (state == SERVE) && ((rem & ~req_grant) == 4'b0);

    assign req_valid  = (state == SERVE);
    assign req_target = (state == SERVE) ? rem : 4'b0;
    assign req_data   = head_data;
    assign req_type   = head_type;
    assign fifo_count = count;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (count != '0) state_next = LOAD;
            LOAD:  state_next = SERVE;
            SERVE: if (pop) state_next = (count_next != '0) ? LOAD : EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    // Storage stage: payload memory carries no reset; pointers and counters do.
    always_ff @(posedge clk) begin
        if (push) begin
            tgt_mem[wr_ptr]  <= in_target;
            data_mem[wr_ptr] <= in_data;
            type_mem[wr_ptr] <= classify(in_target);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_pulse <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            drop_pulse <= drop;
            if (drop) err_count <= sat_inc(err_count);
        end
    end

    // Head stage: type and data are latched once per entry so they stay stable while rem shrinks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem       <= 4'b0;
            head_data <= '0;
            head_type <= 2'b0;
        end else if (state == LOAD) begin
            rem       <= tgt_mem[rd_ptr];
            head_data <= data_mem[rd_ptr];
            head_type <= type_mem[rd_ptr];
        end else if (state == SERVE) begin
            rem <= rem & ~req_grant;
        end
    end

endmodule

// File: doc/switch_port_ingress.md
# switch_port_ingress

Per-port ingress receiver for the 4-port switch: the DUT-side counterpart of the packet driver that pushes packets onto each `port_if`. It accepts single-beat packets from one external port, validates the source/target fields, classifies each packet as SDP, MDP or BDP, and buffers it in a small FIFO. It then presents the head packet to the crossbar with a per-output request mask. Multicast is served by partial grants, so the head is retired only after every target output has taken it.

## Interface
Parameters:
- `PORT_ID`, 0: index (0-3) of the switch port this instance serves.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `DATA_W`, 8: payload width.

Ports:
- `clk`  in  1  switch clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  packet present on the port this cycle.
- `in_source`  in  4  one-hot source port.
- `in_target`  in  4  destination mask.
- `in_data`  in  DATA_W  payload.
- `in_ready`  out  1  ingress can accept a packet this cycle.
- `req_valid`  out  1  head packet pending toward the crossbar.
- `req_target`  out  4  outputs the head packet still has to reach.
- `req_data`  out  DATA_W  head payload.
- `req_type`  out  2  head class: 0 = SDP, 1 = MDP, 2 = BDP.
- `req_grant`  in  4  crossbar grant mask for this cycle.
- `drop_pulse`  out  1  one-cycle pulse when an accepted packet is discarded.
- `err_count`  out  8  saturating count of discarded packets.
- `fifo_count`  out  $clog2(DEPTH)+1  occupancy of the FIFO.

## Operation
- Acceptance: a packet is accepted when `in_valid && in_ready`. Nothing is sampled on other cycles.
- Validation of an accepted packet. The packet is legal only if all of the following hold:
  - `in_source` equals `1<<PORT_ID`.
  - `in_target` is non-zero.
  - `in_target[PORT_ID]` is 0 (no self-loop).
- Illegal packets are not written to the FIFO. The block pulses `drop_pulse` and increments `err_count`, which saturates at 255.
- Classification of legal packets, stored with the entry:
  - popcount(`in_target`) = 1: SDP.
  - popcount = 2: MDP.
  - popcount = 3: BDP (all other ports).
- FIFO: circular buffer with wrap-around read/write pointers. Each entry holds {target, data, type}.
- The head register has three states:
  - EMPTY: FIFO empty; `req_valid` = 0.
  - LOAD: head entry is read into the remaining-mask register `rem`.
  - SERVE: `req_valid` = 1 and `req_target` = `rem`.
- Grants in SERVE: `rem <= rem & ~req_grant`. Grant bits outside `rem` are ignored.
- When `rem & ~req_grant` is 0:
  - The entry is popped.
  - The next state is LOAD if entries remain, otherwise EMPTY.
- `req_type` and `req_data` remain constant while an entry is being served, even as `rem` shrinks.
- `in_ready` = `fifo_count != DEPTH`, computed from registered state. There is no combinational path from `req_grant` to `in_ready`.
- A push and a pop in the same cycle leave `fifo_count` unchanged.

## Timing
- Reset values: `in_ready` = 1; `req_valid` = 0; `req_target` = 0; `req_data` = 0; `req_type` = 0; `drop_pulse` = 0; `err_count` = 0; `fifo_count` = 0; state EMPTY; pointers 0.
- Latency from acceptance (edge N) to `req_valid` = 1 is 2 cycles (edge N+2, via LOAD), measured with the FIFO empty and the head in EMPTY.
- Back-to-back service: the pop edge moves the head to LOAD, and the next entry reaches SERVE one cycle later. This gives a 1-cycle `req_valid` bubble between entries.
- `drop_pulse` rises on the edge after the illegal acceptance and is high for exactly one cycle.
- `fifo_count` updates on the acceptance edge.
- Full: `in_ready` falls on the edge that writes entry DEPTH. It rises on the edge after the pop that frees a slot.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Buffered and in-service packets are discarded.

## Test plan
- Reset, then with `PORT_ID`=0 apply source=0001, target=0100, data=0xA5. Required: `req_valid`=1 two cycles after acceptance with `req_target`=0100 and `req_type`=0. Grant 0100: entry pops and `fifo_count` returns to 0.
- MDP partial grant: target=0110. Grant 0010 first: `req_target` becomes 0100, type stays 1, data unchanged. Then grant 0100: entry pops. A stray grant of 1000 in between changes nothing.
- BDP: target=1110 gives `req_type`=2. Grant 1110 in a single cycle: entry pops immediately.
- Illegal packets, each causing a `drop_pulse` with no FIFO write: source=0010; target=0000; target=0001 (self). `err_count` reaches 3. Then 260 further illegal packets: `err_count` saturates at 255.
- Full and wrap-around: push 4 legal packets with no grants. `in_ready`=0 and `fifo_count`=4, and a fifth `in_valid` is ignored. Drain with grants and push 4 more: data comes out in order across the pointer wrap.
- Reset mid-serve: with 3 entries buffered and the head half-granted, pulse `rst_n` low. All outputs return to their reset values and the next packet is delivered as the first.
